fir_result_checker: RTL

Downstream stage of the FIR test harness. After both FIR variants have filled their 256x26 output memories, this block reads the direct-form and transposed-form results back. It compares them sample by sample, with a programmable index offset and tolerance, and reports pass/fail, mismatch count, first failing address and maximum absolute difference. It drives the read side of both output memories.

---
 rtl/fir_check_pkg.sv | 21 ++
 rtl/fir_result_checker_if.sv | 44 ++++
 rtl/fir_diff_abs.sv | 38 +++
 rtl/fir_result_checker.sv | 132 +++++++++++++
 4 files changed

// File: rtl/fir_check_pkg.sv
// Shared constants and state encoding for the FIR result checker.
// Memory geometry matches the 256x26 FIR output memories.
package fir_check_pkg;
  localparam int DW    = 26;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  localparam int RA_HI = 7;
  localparam int RA_LO = 2;
  localparam int CA_HI = 1;
  localparam int CA_LO = 0;
  localparam int RA_W  = RA_HI - RA_LO + 1;
  localparam int CA_W  = CA_HI - CA_LO + 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/fir_result_checker_if.sv
// Control, result and dual memory read-port bundle of the checker.
// master = checker side, slave = harness/memory side.
interface fir_result_checker_if;
  import fir_check_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [AW:0]          err_count;
  logic                 first_err_valid;
  logic [AW-1:0]        first_err_addr;
  logic [DW:0]          max_abs_diff;

  logic                 d_nce;
  logic                 d_nwrt;
  logic [RA_W-1:0]      d_ra;
  logic [CA_W-1:0]      d_ca;
  logic signed [DW-1:0] d_do;

  logic                 t_nce;
  logic                 t_nwrt;
  logic [RA_W-1:0]      t_ra;
  logic [CA_W-1:0]      t_ca;
  logic signed [DW-1:0] t_do;

  modport master (
    input  start, d_do, t_do,
    output busy, done, pass, err_count,
    output first_err_valid, first_err_addr,
    output max_abs_diff,
    output d_nce, d_nwrt, d_ra, d_ca,
    output t_nce, t_nwrt, t_ra, t_ca
  );

  modport slave (
    output start, d_do, t_do,
    input  busy, done, pass, err_count,
    input  first_err_valid, first_err_addr,
    input  max_abs_diff,
    input  d_nce, d_nwrt, d_ra, d_ca,
    input  t_nce, t_nwrt, t_ra, t_ca
  );
endinterface

// File: rtl/fir_diff_abs.sv
// Compare stage: tracks read-data validity and forms |d - t|
// and the tolerance check for the pair on the memory outputs.
module fir_diff_abs
  import fir_check_pkg::*;
#(
  parameter int TOL = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vld_i,
  input  logic signed [DW-1:0] d_i,
  input  logic signed [DW-1:0] t_i,
  output logic                 vld_o,
  output logic [DW:0]          absdiff_o,
  output logic                 mismatch_o
);
  localparam logic [DW:0] TOL_V = (DW+1)'(TOL);

  logic              vld_d;
  logic              vld_q;
  logic signed [DW:0] diff;

  always_comb vld_d = vld_i;

  always_ff @(posedge clk) begin
    if (reset) vld_q <= 1'b0;
    else       vld_q <= vld_d;
  end

  // One extra bit keeps the difference exact for any pair.
  always_comb begin
    diff = {d_i[DW-1], d_i} - {t_i[DW-1], t_i};
    absdiff_o = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
    mismatch_o = vld_q && (absdiff_o > TOL_V);
  end

  assign vld_o = vld_q;
endmodule

// File: rtl/fir_result_checker.sv
// Reads both FIR output memories back and compares them pairwise,
// accumulating mismatch count, first failing index and max |diff|.
module fir_result_checker
  import fir_check_pkg::*;
#(
  parameter int OFFSET = 0,
  parameter int TOL    = 0
) (
  input logic                  clk,
  input logic                  reset,
  fir_result_checker_if.master bus
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1 - OFFSET);
  localparam logic [AW-1:0] OFF  = AW'(OFFSET);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   err_q, err_d;
  logic          fev_q, fev_d;
  logic [AW-1:0] fea_q, fea_d;
  logic [DW:0]   max_q, max_d;
  logic          pass_q, pass_d;

  logic          rd_en;
  logic [AW-1:0] d_addr;
  logic [AW-1:0] t_addr;
  logic          cmp_vld;
  logic          mism;
  logic [DW:0]   absdiff;

  fir_diff_abs #(.TOL(TOL)) u_diff (
    .clk        (clk),
    .reset      (reset),
    .vld_i      (rd_en),
    .d_i        (bus.d_do),
    .t_i        (bus.t_do),
    .vld_o      (cmp_vld),
    .absdiff_o  (absdiff),
    .mismatch_o (mism)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
      max_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
      max_q   <= max_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = cnt_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fea_d   = fea_q;
    max_d   = max_q;
    pass_d  = pass_q;
    rd_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = READ;
          cnt_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fea_d   = '0;
          max_d   = '0;
          pass_d  = 1'b0;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (cnt_q == LAST) state_d = DRAIN;
        else               cnt_d   = cnt_q + 1'b1;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // addr_q holds the direct index of the pair now on the data bus.
    if (cmp_vld) begin
      if (mism) begin
        err_d = err_q + 1'b1;
        if (!fev_q) begin
          fev_d = 1'b1;
          fea_d = addr_q;
        end
      end
      if (absdiff > max_q) max_d = absdiff;
    end

    if (state_q == DRAIN) pass_d = (err_d == '0);
  end

  assign d_addr = rd_en ? cnt_q : '0;
  assign t_addr = rd_en ? cnt_q + OFF : '0;

  assign bus.d_nce  = ~rd_en;
  assign bus.t_nce  = ~rd_en;
  assign bus.d_nwrt = 1'b1;
  assign bus.t_nwrt = 1'b1;
  assign bus.d_ra   = d_addr[RA_HI:RA_LO];
  assign bus.d_ca   = d_addr[CA_HI:CA_LO];
  assign bus.t_ra   = t_addr[RA_HI:RA_LO];
  assign bus.t_ca   = t_addr[CA_HI:CA_LO];

  assign bus.busy            = (state_q == READ) || (state_q == DRAIN);
  assign bus.done            = (state_q == DONE);
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_addr  = fea_q;
  assign bus.max_abs_diff    = max_q;
endmodule
